// File: rtl/proc_0_irq_aggregator.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : proc_0_irq_aggregator                                       |
// | Purpose  : Avalon-MM slave collecting up to 16 interrupt sources into  |
// |            one processor irq. Each source has a pending latch, an      |
// |            enable mask and an edge/level mode bit; a vector register   |
// |            reports the lowest-numbered active source.                  |
// | Ports    : clk, reset_n (async, active-low)                            |
// |            address[2:0], chipselect, write_n, writedata[15:0]  - bus   |
// |            irq_in[NUM_SRC-1:0]  - source lines, active-high            |
// |            irq_out              - aggregated irq, registered           |
// |            readdata[15:0]       - read data, registered, 1-cycle       |
// | Config   : IRQ_SYNC_EN - when defined, irq_in passes through a 2-flop  |
// |            synchronizer before edge detection and the RAW register.    |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module proc_0_irq_aggregator #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic               irq_out,
    output logic [15:0]        readdata
);

    localparam logic [2:0] c_ADDR_PENDING = 3'd0;
    localparam logic [2:0] c_ADDR_MASK    = 3'd1;
    localparam logic [2:0] c_ADDR_MODE    = 3'd2;
    localparam logic [2:0] c_ADDR_ACTIVE  = 3'd3;
    localparam logic [2:0] c_ADDR_VECTOR  = 3'd4;
    localparam logic [2:0] c_ADDR_RAW     = 3'd6;

    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_mode;
    logic [NUM_SRC-1:0] r_irq_prev;
    logic [NUM_SRC-1:0] w_irq_s;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_irq_s = r_sync2;
`else
    assign w_irq_s = irq_in;
`endif

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic               w_wr;
    logic [NUM_SRC-1:0] w_wdata;
    logic [NUM_SRC-1:0] w_w1c;
    logic [NUM_SRC-1:0] w_force;
    logic               w_unused_wdata;

    assign w_wr    = chipselect & ~write_n;
    assign w_wdata = writedata[NUM_SRC-1:0];
    assign w_w1c   = (w_wr && address == c_ADDR_PENDING) ? w_wdata : '0;
    assign w_force = (w_wr && address == 3'd5)           ? w_wdata : '0;
    // Bits above NUM_SRC are ignored on write.
    assign w_unused_wdata = ^writedata;

    // ------------------------------------------------------------------
    // Pending next-state
    // Edge mode: a new edge or a software force sets the bit and beats a
    // simultaneous W1C. Level mode: the bit simply mirrors the line (or a
    // force), so W1C has no lasting effect while the line is high.
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] w_set_edge;
    logic [NUM_SRC-1:0] w_next_edge;
    logic [NUM_SRC-1:0] w_next_level;
    logic [NUM_SRC-1:0] w_pending_next;

    assign w_set_edge     = (w_irq_s & ~r_irq_prev) | w_force;
    assign w_next_edge    = w_set_edge | (r_pending & ~w_w1c);
    assign w_next_level   = w_irq_s | w_force;
    assign w_pending_next = (r_mode & w_next_edge) | (~r_mode & w_next_level);

    // ------------------------------------------------------------------
    // Active sources and lowest-index vector
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] w_active;
    logic [3:0]         w_vec_idx;

    assign w_active = r_pending & r_mask;

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        w_vec_idx = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_vec_idx = 4'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux (independent of chipselect)
    // ------------------------------------------------------------------
    logic [15:0] w_rd_mux;

    always_comb begin
        w_rd_mux = '0;
        case (address)
            c_ADDR_PENDING: w_rd_mux = 16'(r_pending);
            c_ADDR_MASK:    w_rd_mux = 16'(r_mask);
            c_ADDR_MODE:    w_rd_mux = 16'(r_mode);
            c_ADDR_ACTIVE:  w_rd_mux = 16'(w_active);
            c_ADDR_VECTOR:  w_rd_mux = {|w_active, 11'd0, w_vec_idx};
            c_ADDR_RAW:     w_rd_mux = 16'(w_irq_s);
            default:        w_rd_mux = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending  <= '0;
            r_mask     <= '0;
            r_mode     <= '1;
            r_irq_prev <= '0;
            irq_out    <= 1'b0;
            readdata   <= '0;
        end else begin
            r_pending  <= w_pending_next;
            r_irq_prev <= w_irq_s;
            irq_out    <= |w_active;
            readdata   <= w_rd_mux;
            if (w_wr && address == c_ADDR_MASK) begin
                r_mask <= w_wdata;
            end
            if (w_wr && address == c_ADDR_MODE) begin
                r_mode <= w_wdata;
            end
        end
    end

endmodule
`default_nettype wire
